// File: rtl/mskrc_round_ctrl.sv
// Masked Skinny round-constant generator and round counter. Constant is valid 1 cycle after start/advance.
// No backpressure out: advance low holds every register bit-exact, and a start while busy is ignored.
module mskrc_round_ctrl #(
    parameter int d       = 2,
    parameter int NROUNDS = 56
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             advance,
    input  logic [6*(d-1)-1:0] rnd,
    output logic [6*d-1:0]   roundcst,
    output logic [5:0]       round_idx,
    output logic             busy,
    output logic             last_round,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NROUNDS - 1);

    state_t           state_q, state_d;
    logic [5:0]       rc_q, rc_d;
    logic [5:0]       round_idx_q, round_idx_d;
    logic             done_q, done_d;
    logic [6*d-1:0]   roundcst_q, roundcst_d;
    logic [5:0]       load_rc;
    logic [6*d-1:0]   masked;
    logic             last_q;

    function automatic logic [5:0] lfsr_next(input logic [5:0] v);
        return {v[4:0], v[5] ^ v[4] ^ 1'b1};
    endfunction

    // Value that would be loaded this cycle: the seed from IDLE, the stepped LFSR in RUN.
    always_comb begin
        load_rc = 6'h01;
        if (state_q == RUN) begin
            load_rc = lfsr_next(rc_q);
        end
    end

    // Share 0 absorbs the constant; shares 1..d-1 come straight from rnd.
    always_comb begin
        logic sh0;
        masked = '0;
        sh0    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sh0 = load_rc[i];
            for (int j = 1; j < d; j++) begin
                masked[i*d+j] = rnd[6*(j-1)+i];
                sh0           = sh0 ^ rnd[6*(j-1)+i];
            end
            masked[i*d] = sh0;
        end
    end

    assign last_q = (state_q == RUN) && (round_idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        rc_d        = rc_q;
        round_idx_d = round_idx_q;
        roundcst_d  = roundcst_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    rc_d        = load_rc;
                    round_idx_d = 6'd0;
                    roundcst_d  = masked;
                end
            end
            RUN: begin
                if (advance) begin
                    if (last_q) begin
                        state_d     = IDLE;
                        rc_d        = 6'd0;
                        round_idx_d = 6'd0;
                        roundcst_d  = '0;
                        done_d      = 1'b1;
                    end else begin
                        rc_d        = load_rc;
                        round_idx_d = round_idx_q + 6'd1;
                        roundcst_d  = masked;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rc_q        <= 6'd0;
            round_idx_q <= 6'd0;
            roundcst_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            round_idx_q <= round_idx_d;
            roundcst_q  <= roundcst_d;
            done_q      <= done_d;
        end
    end

    assign roundcst   = roundcst_q;
    assign round_idx  = round_idx_q;
    assign busy       = (state_q == RUN);
    assign last_round = last_q;
    assign done       = done_q;

endmodule
